// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the mux4_rr_arbiter slice: FSM encoding, requester count,
// select width, default data width and the round-robin winner search.
package mux4_rr_arbiter_pkg;

   localparam int NUM_REQ       = 4;
   localparam int SEL_W         = 2;
   localparam int DEFAULT_WIDTH = 5;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Scans from the highest offset down so the first requester at or after ptr wins.
   function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
      logic [SEL_W-1:0] idx;
      rr_pick = ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = ptr + SEL_W'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// Combinational 4:1 mux of WIDTH-bit words packed side by side, word i at [i*WIDTH +: WIDTH].
module mux4_w
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]         select,
   output logic [WIDTH-1:0]         out_data
);

   always_comb begin
      out_data = in_data[select*WIDTH +: WIDTH];
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux onto a valid/ready output bus.
// Optional macro ARB_BURST_EN lets a winner keep the grant for up to MAX_BURST transfers.
module mux4_rr_arbiter
   import mux4_rr_arbiter_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] in_data,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         select,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     busy
);

   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("MAX_BURST must be in 1..15");
   end

   state_t           state;
   logic [SEL_W-1:0] rr_ptr;
   logic [WIDTH-1:0] mux_word;
   logic             xfer;

   mux4_w #(.WIDTH(WIDTH)) u_mux (
      .in_data  (in_data),
      .select   (select),
      .out_data (mux_word)
   );

   // Dropping req[select] pulls out_valid low in the same cycle, hence combinational.
   always_comb begin
      out_valid = (state == GRANT) && req[select];
      out_data  = out_valid ? mux_word : '0;
      xfer      = out_valid && out_ready;
      ack       = '0;
      if (xfer) ack[select] = 1'b1;
   end

`ifdef ARB_BURST_EN
   localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
   logic [3:0] burst_cnt;
   logic       burst_more;

   always_comb begin
      burst_more = ({1'b0, burst_cnt} + 5'd1) < BURST_LIM;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         select <= '0;
         rr_ptr <= '0;
         busy   <= 1'b0;
`ifdef ARB_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  select <= rr_pick(req, rr_ptr);
                  state  <= GRANT;
                  busy   <= 1'b1;
               end
            end
            GRANT: begin
               if (xfer) begin
`ifdef ARB_BURST_EN
                  if (burst_more) begin
                     burst_cnt <= burst_cnt + 4'd1;
                  end else begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     rr_ptr    <= select + 2'd1;
                     burst_cnt <= '0;
                  end
`else
                  state  <= IDLE;
                  busy   <= 1'b0;
                  rr_ptr <= select + 2'd1;
`endif
               end else if (!req[select]) begin
                  // Abort: requester withdrew before transferring, pointer stays put.
                  state <= IDLE;
                  busy  <= 1'b0;
`ifdef ARB_BURST_EN
                  burst_cnt <= '0;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector tables, reset-mid-stall sequence and a
// randomized run checked against a cycle-level behavioural model.
module tb_mux4_rr_arbiter;

   localparam int W    = 5;
   localparam int MAXB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req;
   logic [4*W-1:0] in_data;
   logic          out_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic [1:0]    select;
   logic [3:0]    ack;
   logic          busy;

   int tests = 0;
   int fails = 0;

   mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .select    (select),
      .ack       (ack),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]     req;
      logic [4*W-1:0] data;
      logic           rdy;
      logic           vld;
      logic [1:0]     sel;
      logic [W-1:0]   dat;
      logic [3:0]     ack;
      logic           busy;
   } vec_t;

   localparam logic [4*W-1:0] D1 = {5'b00000, 5'b00000, 5'b00000, 5'b11111};
   localparam logic [4*W-1:0] D2 = {5'b01000, 5'b00100, 5'b00010, 5'b00001};
   localparam logic [4*W-1:0] D3 = {5'b00000, 5'b10101, 5'b00000, 5'b00000};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic vld, input logic [1:0] sel,
                           input logic [W-1:0] dat, input logic [3:0] a, input logic b);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(vld));
      chk({tag, ".select"},    32'(select),    32'(sel));
      chk({tag, ".out_data"},  32'(out_data),  32'(dat));
      chk({tag, ".ack"},       32'(ack),       32'(a));
      chk({tag, ".busy"},      32'(busy),      32'(b));
   endtask

   // Drive one row for one cycle, compare mid-cycle, then step past the edge.
   task automatic run_vec(input vec_t v, input string tag);
      req       = v.req;
      in_data   = v.data;
      out_ready = v.rdy;
      @(negedge clk);
      chk_outs(tag, v.vld, v.sel, v.dat, v.ack, v.busy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", 1'b0, 2'd0, '0, 4'b0000, 1'b0);
      rst_n = 1'b1;
   endtask

   // Behavioural model: grant index (-1 when arbitrating), pointer, last select, burst count.
   int m_grant, m_ptr, m_sel, m_cnt;

   task automatic model_reset();
      m_grant = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_step(input string tag, output logic [3:0] ack_seen);
      logic         e_vld, e_busy;
      logic [1:0]   e_sel;
      logic [W-1:0] e_dat;
      logic [3:0]   e_ack;
      bit           found;
      @(negedge clk);
      if (m_grant >= 0) begin
         e_busy = 1'b1;
         e_sel  = 2'(m_grant);
         e_vld  = req[m_grant];
         e_dat  = e_vld ? in_data[m_grant*W +: W] : '0;
         e_ack  = (e_vld && out_ready) ? 4'(1 << m_grant) : 4'b0000;
      end else begin
         e_busy = 1'b0;
         e_sel  = 2'(m_sel);
         e_vld  = 1'b0;
         e_dat  = '0;
         e_ack  = 4'b0000;
      end
      chk_outs(tag, e_vld, e_sel, e_dat, e_ack, e_busy);
      ack_seen = ack;
      if (m_grant < 0) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && req[(m_ptr + k) % 4]) begin
               m_grant = (m_ptr + k) % 4;
               m_sel   = m_grant;
               found   = 1;
            end
         end
      end else if (e_ack != 0) begin
`ifdef ARB_BURST_EN
         if (m_cnt + 1 < MAXB) begin
            m_cnt++;
         end else begin
            m_ptr   = (m_grant + 1) % 4;
            m_grant = -1;
            m_cnt   = 0;
         end
`else
         m_ptr   = (m_grant + 1) % 4;
         m_grant = -1;
`endif
      end else if (!req[m_grant]) begin
         m_grant = -1;
         m_cnt   = 0;
      end
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[17];
   vec_t abrt[10];
   vec_t brst[7];

   initial begin
      logic [3:0]   last_ack;
      logic [W-1:0] words[4];

      //                req      data rdy vld sel dat       ack      busy
      tbl[0]  = '{4'b0001, D1, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      tbl[1]  = '{4'b0001, D1, 1'b1, 1'b1, 2'd0, 5'b11111, 4'b0001, 1'b1};
      tbl[2]  = '{4'b0000, D1, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      tbl[3]  = '{4'b1111, D2, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      tbl[4]  = '{4'b1111, D2, 1'b1, 1'b1, 2'd1, 5'b00010, 4'b0010, 1'b1};
      tbl[5]  = '{4'b1111, D2, 1'b1, 1'b0, 2'd1, 5'b00000, 4'b0000, 1'b0};
      tbl[6]  = '{4'b1111, D2, 1'b1, 1'b1, 2'd2, 5'b00100, 4'b0100, 1'b1};
      tbl[7]  = '{4'b1111, D2, 1'b1, 1'b0, 2'd2, 5'b00000, 4'b0000, 1'b0};
      tbl[8]  = '{4'b1111, D2, 1'b1, 1'b1, 2'd3, 5'b01000, 4'b1000, 1'b1};
      tbl[9]  = '{4'b1111, D2, 1'b1, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b0};
      tbl[10] = '{4'b1111, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};
      tbl[11] = '{4'b1000, D2, 1'b0, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      tbl[12] = '{4'b1000, D2, 1'b0, 1'b1, 2'd3, 5'b01000, 4'b0000, 1'b1};
      tbl[13] = '{4'b1000, D2, 1'b0, 1'b1, 2'd3, 5'b01000, 4'b0000, 1'b1};
      tbl[14] = '{4'b1000, D2, 1'b0, 1'b1, 2'd3, 5'b01000, 4'b0000, 1'b1};
      tbl[15] = '{4'b1000, D2, 1'b1, 1'b1, 2'd3, 5'b01000, 4'b1000, 1'b1};
      tbl[16] = '{4'b0000, D2, 1'b1, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b0};

      abrt[0] = '{4'b0100, D2, 1'b1, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b0};
      abrt[1] = '{4'b0100, D2, 1'b1, 1'b1, 2'd2, 5'b00100, 4'b0100, 1'b1};
      abrt[2] = '{4'b1001, D2, 1'b0, 1'b0, 2'd2, 5'b00000, 4'b0000, 1'b0};
      abrt[3] = '{4'b1001, D2, 1'b0, 1'b1, 2'd3, 5'b01000, 4'b0000, 1'b1};
      abrt[4] = '{4'b0001, D2, 1'b0, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b1};
      abrt[5] = '{4'b1001, D2, 1'b0, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b0};
      abrt[6] = '{4'b1001, D2, 1'b0, 1'b1, 2'd3, 5'b01000, 4'b0000, 1'b1};
      abrt[7] = '{4'b0001, D2, 1'b1, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b1};
      abrt[8] = '{4'b0001, D2, 1'b1, 1'b0, 2'd3, 5'b00000, 4'b0000, 1'b0};
      abrt[9] = '{4'b0001, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};

      brst[0] = '{4'b0011, D2, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      brst[1] = '{4'b0011, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};
      brst[2] = '{4'b0011, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};
      brst[3] = '{4'b0011, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};
      brst[4] = '{4'b0011, D2, 1'b1, 1'b1, 2'd0, 5'b00001, 4'b0001, 1'b1};
      brst[5] = '{4'b0011, D2, 1'b1, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0};
      brst[6] = '{4'b0011, D2, 1'b1, 1'b1, 2'd1, 5'b00010, 4'b0010, 1'b1};

      // Reset asserted while requester 2 is stalled in GRANT.
      do_reset();
      run_vec('{4'b0100, D3, 1'b0, 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0}, "stall_idle");
      run_vec('{4'b0100, D3, 1'b0, 1'b1, 2'd2, 5'b10101, 4'b0000, 1'b1}, "stall_grant");
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("async_reset", 1'b0, 2'd0, 5'b00000, 4'b0000, 1'b0);
      @(posedge clk);
      #1;

      do_reset();
`ifdef ARB_BURST_EN
      for (int i = 0; i < 7; i++) run_vec(brst[i], $sformatf("burst%0d", i));
`else
      for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
      for (int i = 0; i < 10; i++) run_vec(abrt[i], $sformatf("abort%0d", i));
`endif

      // Randomized traffic against the model; words stay fixed while a request is pending.
      do_reset();
      model_reset();
      last_ack = '0;
      for (int i = 0; i < 4; i++) words[i] = W'($urandom);
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (last_ack[i]) begin
               words[i] = W'($urandom);
               req[i]   = ($urandom_range(0, 1) == 1);
            end else if (req[i]) begin
               if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
            end else begin
               words[i] = W'($urandom);
               req[i]   = ($urandom_range(0, 2) == 0);
            end
         end
         in_data   = {words[3], words[2], words[1], words[0]};
         out_ready = ($urandom_range(0, 3) != 0);
         model_step($sformatf("rand%0d", c), last_ack);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
